// File: rtl/quadrature_gen_if.sv
// Command/status bundle for the quadrature edge generator.
// The master drives commands and abort; the slave (the generator) returns
// handshake status, the two quadrature phases and the running position.
interface quadrature_gen_if #(
   parameter int CNT_W    = 16,
   parameter int PERIOD_W = 24
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_dir;
   logic [CNT_W-1:0]    cmd_count;
   logic [PERIOD_W-1:0] cmd_period;
   logic                abort;
   logic                a;
   logic                b;
   logic                busy;
   logic                done;
   logic [CNT_W-1:0]    position;

   modport master (
      output cmd_valid, cmd_dir, cmd_count, cmd_period, abort,
      input  cmd_ready, a, b, busy, done, position
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_count, cmd_period, abort,
      output cmd_ready, a, b, busy, done, position
   );
endinterface

// File: rtl/quadrature_gen.sv
// Quadrature edge generator (encoder emulator).
// A command asks for N edges in one direction with P clocks between edges.
// Edge k of a command accepted in cycle T becomes visible in cycle T+k*P, so
// the edge register is updated one cycle ahead of that; with P=1 the first
// edge is therefore produced on the very clock that accepts the command.
// The phase is never restored, so consecutive commands continue seamlessly.
module quadrature_gen #(
   parameter int CNT_W    = 16,
   parameter int PERIOD_W = 24
) (
   input logic              clk,
   input logic              reset,
   quadrature_gen_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t              state_q, state_d;
   logic                dir_q, dir_d;
   logic [PERIOD_W-1:0] per_q, per_d;
   logic [PERIOD_W-1:0] tmr_q, tmr_d;      // cycles until the next visible edge
   logic [CNT_W-1:0]    rem_q, rem_d;      // edges still to emit
   logic                a_q, a_d;
   logic                b_q, b_d;
   logic [CNT_W-1:0]    pos_q, pos_d;
   logic [PERIOD_W-1:0] per_eff;
   logic                fire;
   logic                edge_dir;

   // A zero period is treated as one clock per edge
   assign per_eff = (bus.cmd_period == '0) ? PERIOD_W'(1) : bus.cmd_period;

   // Next-state, edge scheduling and phase stepping
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      per_d    = per_q;
      tmr_d    = tmr_q;
      rem_d    = rem_q;
      a_d      = a_q;
      b_d      = b_q;
      pos_d    = pos_q;
      fire     = 1'b0;
      edge_dir = dir_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               dir_d = bus.cmd_dir;
               per_d = per_eff;
               rem_d = bus.cmd_count;
               if (bus.cmd_count == '0) begin
                  state_d = FINISH;
               end else if (per_eff == PERIOD_W'(1)) begin
                  // first edge is due in the very next cycle
                  fire     = 1'b1;
                  edge_dir = bus.cmd_dir;
                  rem_d    = bus.cmd_count - CNT_W'(1);
                  tmr_d    = PERIOD_W'(1);
                  state_d  = (bus.cmd_count == CNT_W'(1)) ? FINISH : RUN;
               end else begin
                  tmr_d   = per_eff - PERIOD_W'(1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               // an edge already visible this cycle has counted; no more follow
               state_d = FINISH;
            end else if (tmr_q == PERIOD_W'(1)) begin
               fire    = 1'b1;
               rem_d   = rem_q - CNT_W'(1);
               tmr_d   = per_q;
               state_d = (rem_q == CNT_W'(1)) ? FINISH : RUN;
            end else begin
               tmr_d = tmr_q - PERIOD_W'(1);
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Gray stepping: up toggles a when a==b else b; down the mirror image
      if (fire) begin
         if (edge_dir) begin
            if (a_q == b_q) a_d = ~a_q;
            else            b_d = ~b_q;
            pos_d = pos_q + CNT_W'(1);
         end else begin
            if (a_q == b_q) b_d = ~b_q;
            else            a_d = ~a_q;
            pos_d = pos_q - CNT_W'(1);
         end
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         per_q   <= PERIOD_W'(1);
         tmr_q   <= '0;
         rem_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         per_q   <= per_d;
         tmr_q   <= tmr_d;
         rem_q   <= rem_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pos_q   <= pos_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == FINISH);
   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.position  = pos_q;

endmodule

// File: tb/tb_quadrature_gen.sv
// Bench for quadrature_gen: expected edge/done events are queued when a
// command is issued and checked by a negedge monitor as the DUT produces them.
module tb_quadrature_gen;

   localparam int CNT_W    = 16;
   localparam int PERIOD_W = 24;

   typedef struct {
      int               cyc;
      logic [1:0]       ab;
      logic [CNT_W-1:0] pos;
      logic             done;
   } ev_t;

   logic clk;
   logic reset;
   int   cyc;
   int   vectors;
   int   miscompares;

   ev_t              sb_q[$];
   logic [1:0]       seq_tab [4];
   int               mdl_idx;
   logic [CNT_W-1:0] mdl_pos;
   logic [1:0]       prev_ab;

   quadrature_gen_if #(.CNT_W(CNT_W), .PERIOD_W(PERIOD_W)) ifc ();

   quadrature_gen #(.CNT_W(CNT_W), .PERIOD_W(PERIOD_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every phase change or done pulse must match the next queued event
   always @(negedge clk) begin
      if (reset) begin
         prev_ab <= 2'b00;
      end else begin
         vectors <= vectors + 1;
         if (ifc.done === 1'b1 && ifc.cmd_ready === 1'b1) begin
            miscompares <= miscompares + 1;
            $display("FAIL done_in_idle: done=%b cmd_ready=%b at cyc %0d", ifc.done, ifc.cmd_ready, cyc);
         end
         if ({ifc.a, ifc.b} !== prev_ab || ifc.done === 1'b1) begin
            if (sb_q.size() == 0) begin
               miscompares <= miscompares + 1;
               $display("FAIL sb_unexpected: ab=%b done=%b pos=%h at cyc %0d, nothing expected",
                        {ifc.a, ifc.b}, ifc.done, ifc.position, cyc);
            end else begin
               ev_t e;
               e = sb_q.pop_front();
               if (e.cyc != cyc || e.ab !== {ifc.a, ifc.b} || e.pos !== ifc.position || e.done !== ifc.done) begin
                  miscompares <= miscompares + 1;
                  $display("FAIL sb_event: got cyc=%0d ab=%b pos=%h done=%b, expected cyc=%0d ab=%b pos=%h done=%b",
                           cyc, {ifc.a, ifc.b}, ifc.position, ifc.done, e.cyc, e.ab, e.pos, e.done);
               end else begin
                  $display("event ok: cyc=%0d ab=%b pos=%h done=%b", cyc, e.ab, e.pos, e.done);
               end
            end
         end
         prev_ab <= {ifc.a, ifc.b};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      int guard = 0;
      while (cyc < target && guard < 20000) begin
         tick();
         guard++;
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      mdl_idx = 0;
      mdl_pos = '0;
   endtask

   // Queue edges k=first..last of a command accepted at t; done marks edge n
   task automatic push_edges(input int t, input bit dir, input int last, input int n, input int p);
      for (int k = 1; k <= last; k++) begin
         ev_t e;
         mdl_idx = dir ? (mdl_idx + 1) % 4 : (mdl_idx + 3) % 4;
         mdl_pos = dir ? mdl_pos + 16'd1 : mdl_pos - 16'd1;
         e.cyc  = t + k * p;
         e.ab   = seq_tab[mdl_idx];
         e.pos  = mdl_pos;
         e.done = (k == n);
         sb_q.push_back(e);
      end
   endtask

   task automatic push_done_only(input int c);
      ev_t e;
      e.cyc  = c;
      e.ab   = seq_tab[mdl_idx];
      e.pos  = mdl_pos;
      e.done = 1'b1;
      sb_q.push_back(e);
   endtask

   // Waits for ready, drives one command for one cycle; returns acceptance cycle
   task automatic issue(input bit dir, input int n, input int p, input bit queue_all, output int t);
      int guard = 0;
      int peff;
      while (ifc.cmd_ready !== 1'b1 && guard < 2000) begin
         tick();
         guard++;
      end
      vectors++;
      if (guard >= 2000) begin
         miscompares++;
         $display("FAIL issue_timeout: cmd_ready=%b required 1", ifc.cmd_ready);
      end
      peff = (p == 0) ? 1 : p;
      ifc.cmd_valid  = 1'b1;
      ifc.cmd_dir    = dir;
      ifc.cmd_count  = CNT_W'(n);
      ifc.cmd_period = PERIOD_W'(p);
      t = cyc;
      if (queue_all) begin
         if (n == 0) push_done_only(t + 1);
         else        push_edges(t, dir, n, n, peff);
      end
      tick();
      ifc.cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((sb_q.size() != 0 || ifc.cmd_ready !== 1'b1) && guard < 5000) begin
         tick();
         guard++;
      end
      tick();
      vectors++;
      if (sb_q.size() != 0 || ifc.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_drain: %0d events outstanding, cmd_ready=%b, required 0 and 1", name, sb_q.size(), ifc.cmd_ready);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({ifc.a, ifc.b, ifc.cmd_ready, ifc.busy, ifc.done} !== 5'b00100 || ifc.position !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_state: a,b,ready,busy,done=%b pos=%h required 00100 0000",
                  {ifc.a, ifc.b, ifc.cmd_ready, ifc.busy, ifc.done}, ifc.position);
      end
   endtask

   task automatic test_up_run();
      int t;
      issue(1'b1, 4, 3, 1'b1, t);
      vectors++;
      if (ifc.cmd_ready !== 1'b0 || ifc.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL up_accept: ready=%b busy=%b required 0 1", ifc.cmd_ready, ifc.busy);
      end
      wait_until(t + 12);
      vectors++;
      if (ifc.done !== 1'b1 || ifc.cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL up_done: done=%b ready=%b at T+12 required 1 0", ifc.done, ifc.cmd_ready);
      end
      tick();
      vectors++;
      if (ifc.cmd_ready !== 1'b1 || ifc.position !== 16'd4 || {ifc.a, ifc.b} !== 2'b00) begin
         miscompares++;
         $display("FAIL up_end: ready=%b pos=%h ab=%b required 1 0004 00", ifc.cmd_ready, ifc.position, {ifc.a, ifc.b});
      end
      drain("up");
   endtask

   task automatic test_down_wrap();
      int t;
      do_reset();
      issue(1'b0, 2, 1, 1'b1, t);
      vectors++;
      if ({ifc.a, ifc.b} !== 2'b01 || ifc.position !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL down_edge1: ab=%b pos=%h required 01 ffff", {ifc.a, ifc.b}, ifc.position);
      end
      tick();
      vectors++;
      if ({ifc.a, ifc.b} !== 2'b11 || ifc.position !== 16'hFFFE || ifc.done !== 1'b1) begin
         miscompares++;
         $display("FAIL down_edge2: ab=%b pos=%h done=%b required 11 fffe 1", {ifc.a, ifc.b}, ifc.position, ifc.done);
      end
      drain("down");
   endtask

   task automatic test_zero_count();
      int t;
      issue(1'b1, 0, 5, 1'b1, t);
      vectors++;
      if (ifc.done !== 1'b1 || ifc.cmd_ready !== 1'b0 || ifc.position !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL zero_done: done=%b ready=%b pos=%h required 1 0 fffe", ifc.done, ifc.cmd_ready, ifc.position);
      end
      tick();
      vectors++;
      if (ifc.cmd_ready !== 1'b1 || ifc.done !== 1'b0 || {ifc.a, ifc.b} !== 2'b11) begin
         miscompares++;
         $display("FAIL zero_ready: ready=%b done=%b ab=%b required 1 0 11", ifc.cmd_ready, ifc.done, {ifc.a, ifc.b});
      end
      drain("zero");
   endtask

   task automatic test_abort();
      int t;
      do_reset();
      issue(1'b1, 10, 4, 1'b0, t);
      push_edges(t, 1'b1, 2, 10, 4);
      push_done_only(t + 10);
      wait_until(t + 9);
      ifc.abort = 1'b1;
      tick();
      ifc.abort = 1'b0;
      vectors++;
      if (ifc.done !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_done: done=%b at T+10 required 1", ifc.done);
      end
      wait_until(t + 12);
      vectors++;
      if ({ifc.a, ifc.b} !== 2'b11 || ifc.position !== 16'd2 || ifc.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_hold: ab=%b pos=%h busy=%b required 11 0002 0", {ifc.a, ifc.b}, ifc.position, ifc.busy);
      end
      drain("abort");
   endtask

   task automatic test_back_to_back();
      int t;
      int t2;
      issue(1'b1, 3, 2, 1'b1, t);
      // conflicting command held while busy must be ignored
      ifc.cmd_valid  = 1'b1;
      ifc.cmd_dir    = 1'b0;
      ifc.cmd_count  = 16'd7;
      ifc.cmd_period = 24'd1;
      wait_until(t + 6);
      ifc.cmd_valid = 1'b0;
      drain("hold");
      vectors++;
      if (ifc.position !== 16'd5) begin
         miscompares++;
         $display("FAIL hold_pos: pos=%h required 0005", ifc.position);
      end
      issue(1'b1, 3, 0, 1'b1, t2);
      drain("p0");
      vectors++;
      if (ifc.position !== 16'd8) begin
         miscompares++;
         $display("FAIL p0_pos: pos=%h required 0008", ifc.position);
      end
   endtask

   task automatic test_async_reset();
      int t;
      issue(1'b1, 10, 64, 1'b1, t);
      wait_until(t + 100);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if ({ifc.a, ifc.b, ifc.cmd_ready, ifc.busy, ifc.done} !== 5'b00100 || ifc.position !== 16'h0000) begin
         miscompares++;
         $display("FAIL async_reset: a,b,ready,busy,done=%b pos=%h required 00100 0000",
                  {ifc.a, ifc.b, ifc.cmd_ready, ifc.busy, ifc.done}, ifc.position);
      end
      model_clear();
      tick();
      tick();
      reset = 1'b0;
      tick();
      issue(1'b0, 1, 2, 1'b1, t);
      drain("post_reset");
      vectors++;
      if (ifc.position !== 16'hFFFF || {ifc.a, ifc.b} !== 2'b01) begin
         miscompares++;
         $display("FAIL post_reset: pos=%h ab=%b required ffff 01", ifc.position, {ifc.a, ifc.b});
      end
   endtask

   initial begin
      seq_tab[0] = 2'b00;
      seq_tab[1] = 2'b10;
      seq_tab[2] = 2'b11;
      seq_tab[3] = 2'b01;
      cyc            = 0;
      vectors        = 0;
      miscompares    = 0;
      prev_ab        = 2'b00;
      mdl_idx        = 0;
      mdl_pos        = '0;
      reset          = 1'b1;
      ifc.cmd_valid  = 1'b0;
      ifc.cmd_dir    = 1'b0;
      ifc.cmd_count  = '0;
      ifc.cmd_period = '0;
      ifc.abort      = 1'b0;
      #12;
      test_reset();
      test_up_run();
      test_down_wrap();
      test_zero_count();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
